csa_addsub_pipe: RTL and testbench

Parametrised carry-skip adder/subtractor, successor to the 8-bit single-register carry-skip adder.
- WIDTH-bit operands split into BLK-bit ripple blocks with per-block skip logic.
- Two pipeline stages: lower half, then upper half. Valid/ready handshake on input and output.
- Outputs carry, signed overflow and zero flags. Used as the shared arithmetic datapath for wider TinyTapeout-style designs.

---
 rtl/csa_pkg.sv | 21 ++
 rtl/csa_skip_block.sv | 38 +++
 rtl/csa_addsub_pipe.sv | 154 +++++++++++++++
 tb/tb_csa_addsub_pipe.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-skip adder/subtractor pipeline.
// Contents: op encoding, default geometry, and a helper that returns the
// two's-complement signed max/min for a given width (used by the optional
// CSA_SAT_EN saturation path).
package csa_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int CSA_WIDTH = 16;
  localparam int CSA_BLK   = 4;

  // Signed limit for a w-bit value, zero-extended to 64 bits.
  // neg=0 -> signed max (0111..1), neg=1 -> signed min (1000..0).
  function automatic logic [63:0] csa_signed_lim(input int unsigned w, input logic neg);
    logic [63:0] msb_only;
    msb_only = 64'd1 << (w - 1);
    return neg ? msb_only : (msb_only - 64'd1);
  endfunction

endpackage

// File: rtl/csa_skip_block.sv
// One carry-skip block: BLK-bit ripple adder plus a skip mux.
// When every bit propagates, the block carry-out is taken straight from the
// block carry-in; otherwise the ripple carry is used. The ripple chain is
// always computed; only the mux chooses.
// Ports:
//   a, b  : BLK-bit operands (b already conditioned for SUB)
//   cin   : carry into the block
//   sum   : BLK-bit sum
//   cout  : carry out of the block (skip or ripple)
module csa_skip_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] sum,
  output logic           cout
);

  logic [BLK:0]   rc;
  logic [BLK-1:0] p;
  logic           skip;

  assign p    = a ^ b;
  assign skip = &p;

  always_comb begin
    rc    = '0;
    rc[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      rc[i+1] = (a[i] & b[i]) | (p[i] & rc[i]);
    end
  end

  assign sum  = p ^ rc[BLK-1:0];
  assign cout = skip ? cin : rc[BLK];

endmodule

// File: rtl/csa_addsub_pipe.sv
// Two-stage pipelined carry-skip adder/subtractor with valid/ready handshake.
// Stage 1 adds the lower WIDTH/2 bits and registers the mid carry together
// with the upper operand halves; stage 2 finishes the upper half and
// registers sum and flags. Throughput is one beat per cycle; in_ready is
// combinational from out_ready (no skid buffer).
// Optional build macro: CSA_SAT_EN -- when defined, a signed overflow
// saturates the sum to signed max/min (chosen by a[MSB]); ovf still reports 1.
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid / in_ready : input handshake
//   op                  : 0 = a+b, 1 = a-b
//   a, b                : WIDTH-bit operands
//   out_valid/out_ready : output handshake
//   sum, cout, ovf, zero: result and flags (cout=1 on SUB means no borrow)
module csa_addsub_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int BLK   = CSA_BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int H   = WIDTH / 2;
  localparam int NBH = H / BLK;

  if (((WIDTH % (2 * BLK)) != 0) || (BLK < 2)) begin : g_bad_geometry
    $fatal(1, "csa_addsub_pipe: WIDTH must be a multiple of 2*BLK and BLK >= 2");
  end

  logic s1_adv, s2_adv, accept;

  // ---------------- stage 0: operand conditioning, lower half ----------------
  logic [WIDTH-1:0] b_cond;
  logic [NBH:0]     lo_c;
  logic [H-1:0]     lo_sum_d;

  assign b_cond  = (op == OP_SUB) ? ~b : b;
  assign lo_c[0] = (op == OP_SUB);

  for (genvar k = 0; k < NBH; k++) begin : g_lo
    csa_skip_block #(.BLK(BLK)) u_blk (
      .a    (a[k*BLK +: BLK]),
      .b    (b_cond[k*BLK +: BLK]),
      .cin  (lo_c[k]),
      .sum  (lo_sum_d[k*BLK +: BLK]),
      .cout (lo_c[k+1])
    );
  end

  // ---------------- stage 1 registers ----------------
  logic         vld_p1_q;
  logic [H-1:0] lo_sum_p1_q;
  logic         mid_c_p1_q;
  logic [H-1:0] hi_a_p1_q;
  logic [H-1:0] hi_b_p1_q;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !vld_p1_q | s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid & s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
    end else if (s1_adv) begin
      vld_p1_q <= in_valid;
    end
  end

  // Data registers are governed by the valid bits, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lo_sum_p1_q <= lo_sum_d;
      mid_c_p1_q  <= lo_c[NBH];
      hi_a_p1_q   <= a[WIDTH-1:H];
      hi_b_p1_q   <= b_cond[WIDTH-1:H];
    end
  end

  // ---------------- stage 1 -> 2: upper half and flags ----------------
  logic [NBH:0]     hi_c;
  logic [H-1:0]     hi_sum;
  logic [WIDTH-1:0] sum_raw, sum_d;
  logic             ovf_d, zero_d, a_msb, b_msb;

  assign hi_c[0] = mid_c_p1_q;
  assign a_msb   = hi_a_p1_q[H-1];
  assign b_msb   = hi_b_p1_q[H-1];

  for (genvar k = 0; k < NBH; k++) begin : g_hi
    csa_skip_block #(.BLK(BLK)) u_blk (
      .a    (hi_a_p1_q[k*BLK +: BLK]),
      .b    (hi_b_p1_q[k*BLK +: BLK]),
      .cin  (hi_c[k]),
      .sum  (hi_sum[k*BLK +: BLK]),
      .cout (hi_c[k+1])
    );
  end

  always_comb begin
    sum_raw = {hi_sum, lo_sum_p1_q};
    ovf_d   = (a_msb == b_msb) & (sum_raw[WIDTH-1] != a_msb);
    sum_d   = sum_raw;
`ifdef CSA_SAT_EN
    // Overflow direction follows the operand sign: positive operands clamp high.
    if (ovf_d) begin
      sum_d = WIDTH'(csa_signed_lim(WIDTH, a_msb));
    end
`endif
    zero_d  = (sum_d == '0);
  end

  // ---------------- stage 2 registers (outputs) ----------------
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q, out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b1;
    end else if (s2_adv) begin
      out_valid_q <= vld_p1_q;
      if (vld_p1_q) begin
        sum_q  <= sum_d;
        cout_q <= hi_c[NBH];
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_csa_addsub_pipe.sv
// Directed bench for csa_addsub_pipe (WIDTH=16, BLK=4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_csa_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout, ovf, zero;

  int compared   = 0;
  int mismatched = 0;

  csa_addsub_pipe #(.WIDTH(16), .BLK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One beat through an idle pipe with out_ready=1, checking latency and result.
  task automatic one_beat(input string tag, input logic o, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] es,
                          input logic ec, input logic eo, input logic ez);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = av; b = bv;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_vld_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_vld"},  32'(out_valid), 32'd1);
    check({tag, "_sum"},  32'(sum),  32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"},  32'(ovf),  32'(eo));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
  endtask

  logic [15:0] sat_sub, sat_add;

  initial begin
`ifdef CSA_SAT_EN
    sat_sub = 16'h8000;
    sat_add = 16'h7FFF;
`else
    sat_sub = 16'h7FFF;
    sat_add = 16'h8000;
`endif
    rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_zero",      32'(zero),      32'd1);
    rst = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);

    one_beat("add_00ff",  1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0);
    one_beat("add_ffff",  1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    one_beat("sub_5_7",   1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    one_beat("sub_8000",  1'b1, 16'h8000, 16'h0001, sat_sub,  1'b1, 1'b1, 1'b0);
    one_beat("add_7fff",  1'b0, 16'h7FFF, 16'h0001, sat_add,  1'b0, 1'b1, 1'b0);

    // Back-to-back with a downstream stall.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h2222;
    check("b2b_rdy1", 32'(in_ready), 32'd1);
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00F1;
    check("b2b_rdy2", 32'(in_ready), 32'd1);
    @(negedge clk);
    op = 1'b1; a = 16'h1234; b = 16'h0234;
    check("b2b_rdy_full", 32'(in_ready),  32'd0);
    check("b2b_vld_stall", 32'(out_valid), 32'd1);
    check("b2b_sum1",      32'(sum),       32'h3333);
    @(negedge clk);
    check("b2b_rdy_hold",  32'(in_ready),  32'd0);
    check("b2b_sum1_hold", 32'(sum),       32'h3333);
    @(negedge clk);
    check("b2b_sum1_hold2", 32'(sum),      32'h3333);
    out_ready = 1'b1;
    #1;
    check("b2b_rdy_release", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_vld2",  32'(out_valid), 32'd1);
    check("b2b_sum2",  32'(sum),       32'h1000);
    check("b2b_cout2", 32'(cout),      32'd0);
    @(negedge clk);
    check("b2b_vld3",  32'(out_valid), 32'd1);
    check("b2b_sum3",  32'(sum),       32'h1000);
    check("b2b_cout3", 32'(cout),      32'd1);
    @(negedge clk);
    check("b2b_drained", 32'(out_valid), 32'd0);

    // Reset with two beats in flight.
    @(negedge clk);
    in_valid = 1'b1; op = 1'b0; a = 16'h0001; b = 16'h0001;
    @(negedge clk);
    a = 16'h0002; b = 16'h0002;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_vld",  32'(out_valid), 32'd0);
    check("mid_rst_sum",  32'(sum),       32'd0);
    check("mid_rst_zero", 32'(zero),      32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 32'(in_ready),  32'd1);
    check("post_rst_vld0", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("post_rst_vld1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("post_rst_vld2", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
